// File: rtl/lab_pkg.sv
// Shared definitions for the 1011 sequence detector: state encoding and
// the next-state / legality helpers used by the FSM.
package lab_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

    function automatic state_e next_state(input state_e cur, input logic b);
        state_e nxt;
        case (cur)
            S0:      nxt = b ? S1    : S0;
            S1:      nxt = b ? S1    : S10;
            S10:     nxt = b ? S101  : S0;
            S101:    nxt = b ? S1011 : S10;
            S1011:   nxt = b ? S1    : S10;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    function automatic logic state_legal(input state_e cur);
        logic ok;
        case (cur)
            S0, S1, S10, S101, S1011: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/seq_detect_counter_if.sv
// Sample stream in, detection results out; master drives samples, slave is the detector.
interface seq_detect_counter_if
    import lab_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic               in_valid;
    logic               in_bit;
    logic               in_bit_n;
    logic               clr;
    logic               detect;
    logic [CNT_W-1:0]   det_count;
    logic               cnt_sat;
    logic               comp_err;
    logic [STATE_W-1:0] state_o;

    modport master (
        output in_valid, in_bit, in_bit_n, clr,
        input  detect, det_count, cnt_sat, comp_err, state_o
    );

    modport slave (
        input  in_valid, in_bit, in_bit_n, clr,
        output detect, det_count, cnt_sat, comp_err, state_o
    );
endinterface

// File: rtl/seq_detect_counter_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is decoded from the count.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count increments, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign sat   = (count_r == CNT_MAX);

endmodule

// File: rtl/seq_detect_counter.sv
// Moore FSM spotting overlapping 1011 on a complementary bit pair, with a
// saturating detection count and a sticky complement-error flag.
module seq_detect_counter
    import lab_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_detect_counter_if.slave  bus
);
    state_e state_r;
    logic   detect_r;
    logic   comp_err_r;
    logic   accept_s;
    logic   pair_bad_s;
    logic   hit_s;

    // Classify the current sample; clr masks both acceptance and the error flag.
    always_comb begin
        accept_s   = bus.in_valid && !bus.clr && (bus.in_bit != bus.in_bit_n);
        pair_bad_s = bus.in_valid && !bus.clr && (bus.in_bit == bus.in_bit_n);
        hit_s      = accept_s && (state_r == S101) && bus.in_bit;
    end

    // FSM with registered detect pulse and sticky error; stray encodings fall back to S0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S0;
            detect_r   <= 1'b0;
            comp_err_r <= 1'b0;
        end else if (bus.clr) begin
            state_r    <= S0;
            detect_r   <= 1'b0;
            comp_err_r <= 1'b0;
        end else begin
            detect_r <= hit_s;
            if (pair_bad_s) begin
                comp_err_r <= 1'b1;
            end else begin
                comp_err_r <= comp_err_r;
            end
            if (!state_legal(state_r)) begin
                state_r <= S0;
            end else if (accept_s) begin
                state_r <= next_state(state_r, bus.in_bit);
            end else begin
                state_r <= state_r;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (hit_s),
        .count (bus.det_count),
        .sat   (bus.cnt_sat)
    );

    assign bus.detect   = detect_r;
    assign bus.comp_err = comp_err_r;
    assign bus.state_o  = state_r;

endmodule

// File: tb/tb_seq_detect_counter.sv
// Directed bench: an 8-bit-count detector plus a 2-bit-count copy for saturation,
// both fed the same sample stream.
module tb_seq_detect_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_detect_counter_if #(.CNT_W(8)) if8 ();
    seq_detect_counter_if #(.CNT_W(2)) if2 ();

    seq_detect_counter #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_detect_counter #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic bn, input logic c);
        if8.in_valid = v; if8.in_bit = b; if8.in_bit_n = bn; if8.clr = c;
        if2.in_valid = v; if2.in_bit = b; if2.in_bit_n = bn; if2.clr = c;
    endtask

    task automatic step(input logic v, input logic b, input logic bn, input logic c);
        drive(v, b, bn, c);
        @(posedge clk);
        #1;
    endtask

    task automatic bitv(input logic b);
        step(1'b1, b, ~b, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all8(input string tag, input logic d, input logic [7:0] cnt,
                            input logic err, input logic [2:0] st);
        chk({tag, ".detect"},   {31'd0, if8.detect},   {31'd0, d});
        chk({tag, ".count"},    {24'd0, if8.det_count}, {24'd0, cnt});
        chk({tag, ".comp_err"}, {31'd0, if8.comp_err}, {31'd0, err});
        chk({tag, ".state"},    {29'd0, if8.state_o},  {29'd0, st});
    endtask

    initial begin
        logic [6:0] ov_bits;
        logic [2:0] ov_state [7];
        logic [6:0] ov_det;
        checks = 0;
        errors = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
        end
        chk_all8("rst", 1'b0, 8'd0, 1'b0, 3'd0);
        chk("rst.sat", {31'd0, if8.cnt_sat}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle();
        idle();
        chk_all8("post_rst", 1'b0, 8'd0, 1'b0, 3'd0);

        // Overlapping stream 1011011
        ov_bits  = 7'b1011011;
        ov_state = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        ov_det   = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            bitv(ov_bits[6-i]);
            chk($sformatf("ov%0d.state", i), {29'd0, if8.state_o}, {29'd0, ov_state[i]});
            chk($sformatf("ov%0d.detect", i), {31'd0, if8.detect}, {31'd0, ov_det[6-i]});
        end
        chk("ov.count", {24'd0, if8.det_count}, 32'd2);
        idle();
        chk_all8("ov_hold", 1'b0, 8'd2, 1'b0, 3'd4);

        // Clear
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all8("clr1", 1'b0, 8'd0, 1'b0, 3'd0);

        // Stall inside the pattern
        bitv(1'b1); bitv(1'b0); bitv(1'b1);
        chk("stall.pre", {29'd0, if8.state_o}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk($sformatf("stall%0d", i), {28'd0, if8.detect, if8.state_o}, 32'd3);
        end
        bitv(1'b1);
        chk_all8("stall.hit", 1'b1, 8'd1, 1'b0, 3'd4);
        idle();
        chk_all8("stall.after", 1'b0, 8'd1, 1'b0, 3'd4);

        // Complement error mid-pattern
        step(1'b0, 1'b0, 1'b0, 1'b1);
        bitv(1'b1); bitv(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all8("cerr", 1'b0, 8'd0, 1'b1, 3'd2);
        bitv(1'b1);
        chk_all8("cerr.b1", 1'b0, 8'd0, 1'b1, 3'd3);
        bitv(1'b1);
        chk_all8("cerr.hit", 1'b1, 8'd1, 1'b1, 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all8("cerr.sticky", 1'b0, 8'd1, 1'b1, 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all8("cerr.clr", 1'b0, 8'd0, 1'b0, 3'd0);

        // Saturation on the 2-bit counter copy
        for (int p = 0; p < 4; p++) begin
            bitv(1'b1); bitv(1'b0); bitv(1'b1); bitv(1'b1);
            chk($sformatf("sat%0d.detect", p), {31'd0, if2.detect}, 32'd1);
            chk($sformatf("sat%0d.count", p), {30'd0, if2.det_count},
                (p < 3) ? 32'(p + 1) : 32'd3);
            chk($sformatf("sat%0d.sat", p), {31'd0, if2.cnt_sat}, (p >= 2) ? 32'd1 : 32'd0);
        end
        chk("sat.count8", {24'd0, if8.det_count}, 32'd4);

        // clr collides with the completing bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        bitv(1'b1); bitv(1'b0); bitv(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_all8("coll", 1'b0, 8'd0, 1'b0, 3'd0);
        idle();
        chk_all8("coll.after", 1'b0, 8'd0, 1'b0, 3'd0);

        // Asynchronous reset right after a detection
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bitv(1'b1); bitv(1'b0); bitv(1'b1); bitv(1'b1);
        chk_all8("arst.pre", 1'b1, 8'd1, 1'b1, 3'd4);
        rst_n = 1'b0;
        #1;
        chk_all8("arst.now", 1'b0, 8'd0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk_all8("arst.rel", 1'b0, 8'd0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_counter.md
Name: seq_detect_counter

Overview:
Downstream consumer of the lab1 combinational mux stage (the 3-input AND / 3-input XNOR selected by `sel`, with `out` and `out_bar` outputs). Samples the `out`/`out_bar` pair as a serial bit stream and detects the overlapping pattern 1011 with a Moore FSM. Counts detections in a saturating counter and flags any sample where the pair is not complementary. This adds the first clocked stage after the combinational datapath and gives the bench an observable, checkable result.

Parameters:
CNT_W, 8, width of the detection counter; saturates at 2^CNT_W-1
STATE_W, 3, width of the debug state output (fixed encoding, not user-tunable)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  current in_bit/in_bit_n pair is a sample to consume
in_bit  input  1  data bit, driven by upstream `out`
in_bit_n  input  1  complement bit, driven by upstream `out_bar`
clr  input  1  synchronous clear of FSM, counter, flags
detect  output  1  one-cycle pulse per completed 1011
det_count  output  CNT_W  number of detections since reset/clr
cnt_sat  output  1  det_count == 2^CNT_W-1
comp_err  output  1  sticky: a valid sample had in_bit == in_bit_n
state_o  output  STATE_W  current FSM state, for debug

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=S0, detect=0, det_count=0, cnt_sat=0, comp_err=0, state_o=0.
- A sample is accepted when in_valid=1, clr=0, and in_bit != in_bit_n.
- Invalid pair: in_valid=1 with in_bit == in_bit_n sets comp_err (sticky). The sample is discarded: state holds, no detect, no count.
- in_valid=0: state, count and flags hold; detect=0.
- State encoding (state_o): S0=0 (no prefix), S1=1 ("1"), S10=2, S101=3, S1011=4 (match).
- Transitions on an accepted bit (b):
  - S0: b=1 -> S1; b=0 -> S0
  - S1: b=1 -> S1; b=0 -> S10
  - S10: b=1 -> S101; b=0 -> S0
  - S101: b=1 -> S1011; b=0 -> S10
  - S1011: b=1 -> S1; b=0 -> S10 (overlap kept)
- detect is registered: high for exactly the one cycle after the clock edge that accepts the bit entering S1011. It is low on every other cycle, even if the FSM stays in S1011 while in_valid=0.
- det_count increments on that same edge. At 2^CNT_W-1 it holds (no wrap) while detect still pulses. cnt_sat is combinational from det_count.
- clr=1 on an edge: state=S0, det_count=0, comp_err=0, detect=0. clr has priority over a simultaneous valid sample, which is dropped.
- Latency: input bit to detect is 1 clock.
- Reset mid-stream: rst_n low asynchronously forces all reset values immediately. The partial prefix is lost.
- No illegal-state lockup: unused encodings 5..7 return to S0 on the next edge regardless of input.

Decomposition:
- Shared package `lab_pkg`: state enum/localparams S0..S1011 and the state width 3.
- One natural sub-module, `sat_counter` (params CNT_W; ports clk, rst_n, clr, inc, count, sat), instantiated once.
- The FSM stays in seq_detect_counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> all outputs 0, state_o=0. Release -> outputs unchanged until the first valid sample.
- Overlap: stream 1,0,1,1,0,1,1 with in_valid=1 and in_bit_n=~in_bit -> detect pulses after bit 4 and after bit 7; det_count=2; final state_o=4.
- Stall: stream 1,0,1 -> wait 5 cycles with in_valid=0 -> send 1 -> detect exactly 1 cycle after the final 1. No pulse during the gaps; det_count=1.
- Complement error: send in_bit=1, in_bit_n=1 mid-pattern (after 1,0) -> comp_err=1 and state_o stays 2. Follow with 1,1 -> detect pulses; comp_err stays 1 until clr.
- Saturation (CNT_W=2): 4 back-to-back patterns 1011 1011 1011 1011 -> det_count 1,2,3,3; cnt_sat=1 after the 3rd; detect pulses all 4 times.
- clr collision: clr=1 in the same cycle as the final 1 of 1011 -> no detect, det_count=0, state_o=0. An async rst_n pulse mid-pattern -> outputs 0 immediately, not at the next edge.
